// File: rtl/uart_cmd_sequencer_if.sv
// Handshake bundle between the UART command wrapper / execution datapath and the sequencer.
// master = sequencer side, slave = wrapper + datapath side.
interface uart_cmd_sequencer_if;
   localparam int unsigned CMD_W  = 16;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned OP_W   = 4;
   localparam int unsigned ARG_W  = 12;

   logic              cmd_rdy;
   logic [CMD_W-1:0]  cmd;
   logic              clr_cmd_rdy;
   logic [BYTE_W-1:0] resp;
   logic              send_resp;
   logic              resp_sent;

   logic              exec_req;
   logic [OP_W-1:0]   exec_op;
   logic [ARG_W-1:0]  exec_arg;
   logic              exec_ack;
   logic              exec_err;
   logic [BYTE_W-1:0] exec_data;

   modport master (
      input  cmd_rdy, cmd, resp_sent, exec_ack, exec_err, exec_data,
      output clr_cmd_rdy, resp, send_resp, exec_req, exec_op, exec_arg
   );

   modport slave (
      output cmd_rdy, cmd, resp_sent, exec_ack, exec_err, exec_data,
      input  clr_cmd_rdy, resp, send_resp, exec_req, exec_op, exec_arg
   );
endinterface

// File: rtl/uart_cmd_sequencer.sv
// Command sequencer: accepts one 16-bit UART command at a time, dispatches it to the
// execution datapath and returns exactly one response byte per command.
module uart_cmd_sequencer #(
   parameter int unsigned TIMEOUT_CYC = 1000,
   parameter logic [15:0] VALID_OPS   = 16'h00FF,
   parameter logic [15:0] READ_OPS    = 16'h0030,
   parameter logic [7:0]  ACK_BYTE    = 8'hA5,
   parameter logic [7:0]  NAK_BYTE    = 8'hEE
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   uart_cmd_sequencer_if.master  bus,
   output logic                  busy_o,
   output logic [7:0]            nak_cnt_o
);

   localparam int unsigned TIMER_W = 16;
   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned OP_W    = 4;
   localparam int unsigned ARG_W   = 12;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
   localparam logic [BYTE_W-1:0]  NAK_SAT    = 8'hFF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_EXEC,
      S_RESP,
      S_WAIT_TX
   } state_e;

   state_e              state_q;
   logic [TIMER_W-1:0]  timer_q;
   logic [BYTE_W-1:0]   resp_q;
   logic [OP_W-1:0]     op_q;
   logic [ARG_W-1:0]    arg_q;
   logic [BYTE_W-1:0]   nak_cnt_q;

   logic [BYTE_W-1:0]   exec_resp_d;
   logic                timeout_d;

   // Response byte selected on a datapath completion.
   always_comb begin
      exec_resp_d = ACK_BYTE;
      if (bus.exec_err) begin
         exec_resp_d = NAK_BYTE;
      end else if (READ_OPS[op_q]) begin
         exec_resp_d = bus.exec_data;
      end
   end

   assign timeout_d = (timer_q == TIMER_LAST);

   // Sequencer state machine; the timer cannot wrap because EXEC is left at TIMER_LAST.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         resp_q    <= '0;
         op_q      <= '0;
         arg_q     <= '0;
         nak_cnt_q <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.cmd_rdy) begin
                  op_q    <= bus.cmd[15:12];
                  arg_q   <= bus.cmd[11:0];
                  state_q <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (!VALID_OPS[op_q]) begin
                  resp_q  <= NAK_BYTE;
                  state_q <= S_RESP;
               end else begin
                  timer_q <= '0;
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               timer_q <= timer_q + TIMER_W'(1);
               if (bus.exec_ack) begin
                  resp_q  <= exec_resp_d;
                  state_q <= S_RESP;
               end else if (timeout_d) begin
                  resp_q  <= NAK_BYTE;
                  state_q <= S_RESP;
               end
            end
            S_RESP: begin
               if (resp_q == NAK_BYTE && nak_cnt_q != NAK_SAT) begin
                  nak_cnt_q <= nak_cnt_q + BYTE_W'(1);
               end
               state_q <= S_WAIT_TX;
            end
            S_WAIT_TX: begin
               if (bus.resp_sent) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Strobes and levels are pure decodes of the state register.
   assign bus.clr_cmd_rdy = (state_q == S_DECODE);
   assign bus.exec_req    = (state_q == S_EXEC);
   assign bus.send_resp   = (state_q == S_RESP);
   assign bus.resp        = resp_q;
   assign bus.exec_op     = op_q;
   assign bus.exec_arg    = arg_q;
   assign busy_o          = (state_q != S_IDLE);
   assign nak_cnt_o       = nak_cnt_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Randomized bench for uart_cmd_sequencer against a per-command transaction model.
module tb_uart_cmd_sequencer;

   localparam int unsigned TO    = 8;
   localparam logic [15:0] VALID = 16'h00FF;
   localparam logic [15:0] READS = 16'h0030;
   localparam logic [7:0]  ACK   = 8'hA5;
   localparam logic [7:0]  NAK   = 8'hEE;

   logic       clk = 1'b0;
   logic       rst;
   logic       busy;
   logic [7:0] nak_cnt;

   int n_checks  = 0;
   int n_errors  = 0;
   int nak_model = 0;

   uart_cmd_sequencer_if bus();

   uart_cmd_sequencer #(
      .TIMEOUT_CYC (TO),
      .VALID_OPS   (VALID),
      .READ_OPS    (READS),
      .ACK_BYTE    (ACK),
      .NAK_BYTE    (NAK)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .bus       (bus.master),
      .busy_o    (busy),
      .nak_cnt_o (nak_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Runs one command starting in an IDLE cycle; returns in the first IDLE cycle afterwards.
   task automatic do_cmd(input logic [15:0] c, input int ack_at, input bit err,
                         input logic [7:0] data, input bit chain, input logic [15:0] next_c);
      logic [3:0] op;
      logic [7:0] exp_resp;
      int exp_exec, exp_send;
      int exec_seen, send_cnt, send_cyc, clr_cnt, tx_cyc;
      logic [7:0] resp_seen;
      bit stable_ok, done;

      op = c[15:12];
      if (!VALID[op]) begin
         exp_resp = NAK; exp_exec = 0; exp_send = 2;
      end else if (ack_at >= 1 && ack_at <= int'(TO)) begin
         exp_resp = err ? NAK : (READS[op] ? data : ACK);
         exp_exec = ack_at; exp_send = ack_at + 2;
      end else begin
         exp_resp = NAK; exp_exec = int'(TO); exp_send = int'(TO) + 2;
      end
      if (exp_resp == NAK && nak_model < 255) nak_model++;

      exec_seen = 0; send_cnt = 0; send_cyc = -1; clr_cnt = 0; tx_cyc = -1;
      resp_seen = '0; stable_ok = 1'b1; done = 1'b0;

      check_eq("idle_busy", 32'(busy), 32'd0);
      bus.cmd_rdy = 1'b1;
      bus.cmd     = c;

      for (int cyc = 1; cyc <= int'(TO) + 30 && !done; cyc++) begin
         @(posedge clk); #1;
         if (tx_cyc >= 0 && cyc == tx_cyc + 1) begin
            bus.resp_sent = 1'b0;
            bus.exec_ack  = 1'b0;
            done = 1'b1;
         end else begin
            if (bus.clr_cmd_rdy) clr_cnt++;
            if (cyc == 1) begin
               check_eq("clr_at_1", 32'(bus.clr_cmd_rdy), 32'd1);
               check_eq("exec_op", 32'(bus.exec_op), 32'(c[15:12]));
               check_eq("exec_arg", 32'(bus.exec_arg), 32'(c[11:0]));
            end
            if (cyc == 2) bus.cmd_rdy = 1'b0;
            if (bus.exec_req) begin
               exec_seen++;
               bus.exec_ack = (exec_seen == ack_at);
               if (exec_seen == ack_at) begin
                  bus.exec_err  = err;
                  bus.exec_data = data;
               end else begin
                  bus.exec_err  = 1'($urandom);
                  bus.exec_data = 8'($urandom);
               end
            end else begin
               bus.exec_ack  = (ack_at > int'(TO) && exec_seen == int'(TO)) ? 1'b1 : 1'($urandom);
               bus.exec_err  = 1'($urandom);
               bus.exec_data = 8'($urandom);
            end
            if (bus.send_resp) begin
               send_cnt++;
               if (send_cyc < 0) begin
                  send_cyc  = cyc;
                  resp_seen = bus.resp;
                  tx_cyc    = cyc + 1 + int'($urandom % 3);
               end
            end else if (send_cyc >= 0 && bus.resp !== resp_seen) begin
               stable_ok = 1'b0;
            end
            if (send_cyc >= 0) bus.resp_sent = (cyc == tx_cyc);
            else               bus.resp_sent = 1'($urandom);
            if (chain && send_cyc >= 0 && cyc == send_cyc + 1) begin
               bus.cmd_rdy = 1'b1;
               bus.cmd     = next_c;
            end
         end
      end

      check_eq("cmd_done", 32'(done), 32'd1);
      check_eq("clr_pulses", 32'(clr_cnt), 32'd1);
      check_eq("send_pulses", 32'(send_cnt), 32'd1);
      check_eq("send_cycle", 32'(send_cyc), 32'(exp_send));
      check_eq("resp", 32'(resp_seen), 32'(exp_resp));
      check_eq("exec_cycles", 32'(exec_seen), 32'(exp_exec));
      check_eq("resp_stable", 32'(stable_ok), 32'd1);
      check_eq("nak_cnt", 32'(nak_cnt), 32'(nak_model));
      check_eq("end_busy", 32'(busy), 32'd0);
      check_eq("op_held", 32'({bus.exec_op, bus.exec_arg}), 32'(c));
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not end, got running expected finished");
      $fatal(1);
   end

   initial begin
      logic [15:0] cur, nxt;
      bit ch;
      rst = 1'b1;
      bus.cmd_rdy = 1'b0; bus.cmd = '0; bus.resp_sent = 1'b0;
      bus.exec_ack = 1'b0; bus.exec_err = 1'b0; bus.exec_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_clr", 32'(bus.clr_cmd_rdy), 32'd0);
      check_eq("rst_send", 32'(bus.send_resp), 32'd0);
      check_eq("rst_req", 32'(bus.exec_req), 32'd0);
      check_eq("rst_resp", 32'(bus.resp), 32'd0);
      check_eq("rst_oparg", 32'({bus.exec_op, bus.exec_arg}), 32'd0);
      check_eq("rst_nak", 32'(nak_cnt), 32'd0);
      rst = 1'b0;

      do_cmd(16'h1ABC, 3, 1'b0, 8'h00, 1'b0, 16'h0);
      do_cmd(16'h4005, 2, 1'b0, 8'h3C, 1'b0, 16'h0);
      do_cmd(16'hF000, 0, 1'b0, 8'h00, 1'b0, 16'h0);
      check_eq("nak_after_illegal", 32'(nak_cnt), 32'd1);
      do_cmd(16'h2000, 0, 1'b0, 8'h00, 1'b0, 16'h0);
      do_cmd(16'h2001, 9, 1'b0, 8'h00, 1'b0, 16'h0);
      do_cmd(16'h2002, 8, 1'b0, 8'h00, 1'b0, 16'h0);
      do_cmd(16'h3003, 1, 1'b1, 8'h00, 1'b0, 16'h0);
      do_cmd(16'h1111, 2, 1'b0, 8'h00, 1'b1, 16'h5222);
      do_cmd(16'h5222, 1, 1'b0, 8'h77, 1'b0, 16'h0);

      cur = 16'($urandom);
      for (int i = 0; i < 60; i++) begin
         nxt = 16'($urandom);
         ch  = 1'($urandom);
         do_cmd(cur, int'($urandom % 11), 1'($urandom), 8'($urandom), ch, nxt);
         cur = nxt;
      end

      for (int i = 0; i < 300; i++) begin
         do_cmd({4'h8 | 4'($urandom % 8), 12'($urandom)}, 1, 1'b0, 8'h00, 1'b0, 16'h0);
      end
      check_eq("nak_saturated", 32'(nak_cnt), 32'hFF);

      bus.cmd_rdy = 1'b1;
      bus.cmd     = 16'h2345;
      bus.exec_ack = 1'b0;
      for (int k = 0; k < 5 && !bus.exec_req; k++) begin
         @(posedge clk); #1;
         if (bus.clr_cmd_rdy) bus.cmd_rdy = 1'b0;
      end
      check_eq("pre_rst_req", 32'(bus.exec_req), 32'd1);
      bus.cmd_rdy = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      nak_model = 0;
      check_eq("mid_rst_req", 32'(bus.exec_req), 32'd0);
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      check_eq("mid_rst_send", 32'(bus.send_resp), 32'd0);
      check_eq("mid_rst_nak", 32'(nak_cnt), 32'd0);
      @(posedge clk); #1;
      check_eq("post_rst_send", 32'(bus.send_resp), 32'd0);
      do_cmd(16'h5ABC, 4, 1'b0, 8'h42, 1'b0, 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
